mul_pipe: RTL and testbench
===========================

Name: mul_pipe

Overview:
- Parametrised, back-pressurable successor to the fixed-latency integer multiplier in the execute cluster.
- Accepts MUL, MULT/MULTU, MADD/MADDU and MSUB/MSUBU micro-ops and carries their ROB and PRF tags down a LAT-deep pipeline.
- Delivers results to the writeback arbiter with a valid/stall handshake.
- Supports a full squash on pipeline flush, and bubble-collapse so a stalled head does not freeze empty stages.

Parameters:
- W, 32: operand width; product and hilo are 2W bits.
- LAT, 4: pipeline depth; must be at least 1. Issue-to-result latency is LAT cycles when there is no stall.
- ROB_W, `LG_ROB_ENTRIES: ROB pointer width.
- PRF_W, `LG_PRF_ENTRIES: GPR PRF pointer width.
- HILO_W, `LG_HILO_PRF_ENTRIES: hilo PRF pointer width.

Ports:
- clk  in  1  clock. One clock; all state is updated on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash every in-flight op; takes effect on the next edge.
- go  in  1  issue valid.
- ready  out  1  pipeline can accept an op this cycle. Issue happens when go and ready are both high.
- unsigned_mul  in  1  operands are treated as unsigned.
- is_mul  in  1  result goes to the GPR (low W bits); otherwise it goes to hilo.
- is_madd  in  1  accumulate: y = product + src_hilo.
- is_msub  in  1  subtract: y = product - src_hilo.
- src_A, src_B  in  W  operands.
- src_hilo  in  2W  accumulator input.
- rob_ptr_in  in  ROB_W  ROB tag of the issuing op.
- gpr_prf_ptr_in  in  PRF_W  GPR destination tag.
- hilo_prf_ptr_in  in  HILO_W  hilo destination tag.
- wb_stall  in  1  writeback did not take the head result this cycle.
- complete  out  1  head stage holds a valid result.
- y  out  2W  result.
- rob_ptr_out  out  ROB_W  ROB tag of the result.
- gpr_prf_ptr_val_out  out  1  result writes the GPR PRF.
- gpr_prf_ptr_out  out  PRF_W  GPR destination tag.
- hilo_prf_ptr_val_out  out  1  result writes the hilo PRF.
- hilo_prf_ptr_out  out  HILO_W  hilo destination tag.

Behaviour:
- Reset: every stage valid bit is 0 and every data/tag register is 0. Outputs are therefore complete=0, y=0, all tag outputs 0, both *_val_out=0, ready=1.
- Stage 0 captures the following on an accepted issue:
  - the 2W-bit product: signed when unsigned_mul=0, unsigned when unsigned_mul=1;
  - src_hilo;
  - the madd/msub flags;
  - all tags;
  - gpr_val = is_mul, hilo_val = !is_mul.
- Stages 1..LAT-1 copy the previous stage; stage LAT-1 is the head.
- Advance rule:
  - move[LAT-1] = !wb_stall | !valid[LAT-1].
  - move[i] = move[i+1] | !valid[i+1].
  - A stage that does not move holds its contents.
  - A stage that moves without a valid predecessor becomes invalid.
- ready equals move[0] computed with valid[-1] taken as 0, i.e. the stage-0 slot frees this cycle. ready is combinational and does not depend on go.
- Output, driven combinationally from the head stage:
  - complete = valid[LAT-1].
  - y = prod + hilo when madd, prod - hilo when msub, otherwise prod.
  - Arithmetic wraps modulo 2^(2W).
- Illegal input: is_madd and is_msub both high is illegal; madd takes priority.
- An MUL op still produces the full 2W-bit y; the consumer takes the low W bits.
- A result is consumed on any cycle with complete=1 and wb_stall=0.
- Flush: all valid bits clear on the next edge. Flush overrides a same-cycle issue, which is dropped. Tags and data need not clear.
- Reset or flush mid-stall: the pipeline empties; the stalled head result is discarded.
- Simultaneous consume and issue with a full pipe: everything shifts and the new op enters stage 0. Throughput is 1 op/cycle.
- With wb_stall held high and the pipe full: ready=0 and contents are frozen. complete stays 1 with the same y and tags every cycle.

Optional Feature:
- Macro: MUL_PIPE_PERF_EN.
- When defined, the block adds two output ports:
  - perf_ops, 32 bits: counts consumed results.
  - perf_stall, 32 bits: counts cycles with complete & wb_stall.
- Both counters reset to 0 on reset, wrap at 2^32, and are not affected by flush.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. W=32, LAT=4, MULT signed, A=0xFFFFFFFF, B=2, no stall -> complete at cycle +4; y=0xFFFFFFFFFFFFFFFE; hilo_prf_ptr_val_out=1, gpr_prf_ptr_val_out=0.
2. MADDU, A=0xFFFFFFFF, B=0xFFFFFFFF, src_hilo=0x2 -> y=0xFFFFFFFE00000003. MSUB, A=1, B=1, src_hilo=2 -> y=0xFFFFFFFFFFFFFFFF.
3. Back-to-back issue of 6 MUL ops with rob tags 0..5, wb_stall high for cycles 4..7:
   - ready drops after the 4th op;
   - each tag completes exactly once, in order 0..5;
   - no result is lost or duplicated.
4. Two ops in flight at stages 0 and 2, with flush in the same cycle as a go -> complete stays 0 for the next 8 cycles; ready=1 on the following cycle.
5. Reset asserted while the pipe is full and stalled -> on the next cycle complete=0, y=0, ready=1. A subsequent MUL with A=3, B=5 gives y=15 after 4 cycles.
6. With MUL_PIPE_PERF_EN defined: 3 consumed ops and 2 stall cycles -> perf_ops=3, perf_stall=2. After reset both read 0.

Source files
------------

// File: rtl/mul_pipe.sv
// mul_pipe: back-pressurable LAT-deep integer multiply/accumulate pipeline with flush and bubble-collapse.
// Optional perf counters (perf_ops, perf_stall) are enabled by defining MUL_PIPE_PERF_EN.

`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 6
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 6
`endif
`ifndef LG_HILO_PRF_ENTRIES
`define LG_HILO_PRF_ENTRIES 2
`endif

module mul_pipe #(
  parameter int W      = 32,
  parameter int LAT    = 4,
  parameter int ROB_W  = `LG_ROB_ENTRIES,
  parameter int PRF_W  = `LG_PRF_ENTRIES,
  parameter int HILO_W = `LG_HILO_PRF_ENTRIES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              go,
  output logic              ready,
  input  logic              unsigned_mul,
  input  logic              is_mul,
  input  logic              is_madd,
  input  logic              is_msub,
  input  logic [W-1:0]      src_A,
  input  logic [W-1:0]      src_B,
  input  logic [2*W-1:0]    src_hilo,
  input  logic [ROB_W-1:0]  rob_ptr_in,
  input  logic [PRF_W-1:0]  gpr_prf_ptr_in,
  input  logic [HILO_W-1:0] hilo_prf_ptr_in,
  input  logic              wb_stall,
  output logic              complete,
  output logic [2*W-1:0]    y,
  output logic [ROB_W-1:0]  rob_ptr_out,
  output logic              gpr_prf_ptr_val_out,
  output logic [PRF_W-1:0]  gpr_prf_ptr_out,
  output logic              hilo_prf_ptr_val_out,
  output logic [HILO_W-1:0] hilo_prf_ptr_out
`ifdef MUL_PIPE_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_stall
`endif
);

  typedef struct packed {
    logic [2*W-1:0]    prod;
    logic [2*W-1:0]    hilo;
    logic              madd;
    logic              msub;
    logic [ROB_W-1:0]  rob;
    logic [PRF_W-1:0]  gpr;
    logic [HILO_W-1:0] hptr;
    logic              gpr_val;
    logic              hilo_val;
  } stage_t;

  stage_t         stg [LAT];
  stage_t         in_stage;
  stage_t         head;
  logic [LAT-1:0] valid;
  logic [LAT-1:0] move;
  logic [LAT-1:0] load;

  // Sign- or zero-extend both operands to 2W so one multiplier serves both signednesses.
  logic [2*W-1:0] ext_a, ext_b;
  logic           sign_a, sign_b;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    in_stage          = '0;
    sign_a            = !unsigned_mul && src_A[W-1];
    sign_b            = !unsigned_mul && src_B[W-1];
    ext_a             = {{W{sign_a}}, src_A};
    ext_b             = {{W{sign_b}}, src_B};
    in_stage.prod     = ext_a * ext_b;
    in_stage.hilo     = src_hilo;
    in_stage.madd     = is_madd;
    in_stage.msub     = is_msub;
    in_stage.rob      = rob_ptr_in;
    in_stage.gpr      = gpr_prf_ptr_in;
    in_stage.hptr     = hilo_prf_ptr_in;
    in_stage.gpr_val  = is_mul;
    in_stage.hilo_val = !is_mul;
  end

  // move[i]: stage i's contents leave this cycle. load[i]: stage i takes its predecessor,
  // which also lets an empty stage fill behind a stalled successor (bubble-collapse).
  logic m;
  always_comb begin
    move        = '0;
    m           = !wb_stall || !valid[LAT-1];
    move[LAT-1] = m;
    for (int i = LAT-2; i >= 0; i--) begin
      m       = m || !valid[i+1];
      move[i] = m;
    end
    load = move | ~valid;
  end

  assign ready = load[0];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (reset) begin
      valid <= '0;
      // NOTE: data/tag registers are reset too, so outputs read as zero straight out of reset.
      for (int i = 0; i < LAT; i++) stg[i] <= '0;
    end else begin
      if (load[0]) begin
        stg[0]   <= in_stage;
        valid[0] <= go;
      end
      for (int i = 1; i < LAT; i++) begin
        if (load[i]) begin
          stg[i]   <= stg[i-1];
          valid[i] <= valid[i-1];
        end
      end
      if (flush) valid <= '0;
    end
  end

  assign head                 = stg[LAT-1];
  assign complete             = valid[LAT-1];
  assign rob_ptr_out          = head.rob;
  assign gpr_prf_ptr_val_out  = head.gpr_val;
  assign gpr_prf_ptr_out      = head.gpr;
  assign hilo_prf_ptr_val_out = head.hilo_val;
  assign hilo_prf_ptr_out     = head.hptr;

  // madd wins when both accumulate flags are set.
  always_comb begin
    if (head.madd)      y = head.prod + head.hilo;
    else if (head.msub) y = head.prod - head.hilo;
    else                y = head.prod;
  end

`ifdef MUL_PIPE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (complete && !wb_stall) perf_ops   <= perf_ops + 32'd1;
      if (complete && wb_stall)  perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_pipe.sv
// Directed self-checking bench for mul_pipe (W=32, LAT=4); perf checks run when MUL_PIPE_PERF_EN is defined.
module tb_mul_pipe;
  localparam int W = 32, LAT = 4, ROB_W = 6, PRF_W = 6, HILO_W = 2;

  logic              clk = 1'b0;
  logic              reset, flush, go, ready;
  logic              unsigned_mul, is_mul, is_madd, is_msub;
  logic [W-1:0]      src_A, src_B;
  logic [2*W-1:0]    src_hilo;
  logic [ROB_W-1:0]  rob_ptr_in;
  logic [PRF_W-1:0]  gpr_prf_ptr_in;
  logic [HILO_W-1:0] hilo_prf_ptr_in;
  logic              wb_stall, complete;
  logic [2*W-1:0]    y;
  logic [ROB_W-1:0]  rob_ptr_out;
  logic              gpr_prf_ptr_val_out, hilo_prf_ptr_val_out;
  logic [PRF_W-1:0]  gpr_prf_ptr_out;
  logic [HILO_W-1:0] hilo_prf_ptr_out;
`ifdef MUL_PIPE_PERF_EN
  logic [31:0]       perf_ops, perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mul_pipe #(.W(W), .LAT(LAT), .ROB_W(ROB_W), .PRF_W(PRF_W), .HILO_W(HILO_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .go(go), .ready(ready),
    .unsigned_mul(unsigned_mul), .is_mul(is_mul), .is_madd(is_madd), .is_msub(is_msub),
    .src_A(src_A), .src_B(src_B), .src_hilo(src_hilo),
    .rob_ptr_in(rob_ptr_in), .gpr_prf_ptr_in(gpr_prf_ptr_in), .hilo_prf_ptr_in(hilo_prf_ptr_in),
    .wb_stall(wb_stall), .complete(complete), .y(y), .rob_ptr_out(rob_ptr_out),
    .gpr_prf_ptr_val_out(gpr_prf_ptr_val_out), .gpr_prf_ptr_out(gpr_prf_ptr_out),
    .hilo_prf_ptr_val_out(hilo_prf_ptr_val_out), .hilo_prf_ptr_out(hilo_prf_ptr_out)
`ifdef MUL_PIPE_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic u, input logic m, input logic ma, input logic ms,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] h,
                        input logic [ROB_W-1:0] r, input logic [PRF_W-1:0] g,
                        input logic [HILO_W-1:0] hp);
    go = 1'b1; unsigned_mul = u; is_mul = m; is_madd = ma; is_msub = ms;
    src_A = a; src_B = b; src_hilo = h;
    rob_ptr_in = r; gpr_prf_ptr_in = g; hilo_prf_ptr_in = hp;
  endtask

  task automatic idle();
    go = 1'b0; is_madd = 1'b0; is_msub = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; wb_stall = 1'b0; idle();
    step(); step();
    n_checks++; if (complete !== 1'b0) begin n_fail++; $display("FAIL reset_complete: got %b want 0", complete); end
    n_checks++; if (y !== 64'h0) begin n_fail++; $display("FAIL reset_y: got %h want 0", y); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++; if (rob_ptr_out !== '0) begin n_fail++; $display("FAIL reset_rob: got %h want 0", rob_ptr_out); end
    n_checks++; if (gpr_prf_ptr_val_out !== 1'b0 || hilo_prf_ptr_val_out !== 1'b0)
      begin n_fail++; $display("FAIL reset_vals: got %b%b want 00", gpr_prf_ptr_val_out, hilo_prf_ptr_val_out); end
    n_checks++; if (gpr_prf_ptr_out !== '0 || hilo_prf_ptr_out !== '0)
      begin n_fail++; $display("FAIL reset_tags: got %h/%h want 0/0", gpr_prf_ptr_out, hilo_prf_ptr_out); end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 64'h0, 6'd3, 6'd5, 2'd1);
    step(); idle();
    for (int k = 1; k < LAT; k++) begin
      n_checks++; if (complete !== 1'b0) begin n_fail++; $display("FAIL mult_early_%0d: got %b want 0", k, complete); end
      step();
    end
    n_checks++; if (complete !== 1'b1) begin n_fail++; $display("FAIL mult_complete: got %b want 1", complete); end
    n_checks++; if (y !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL mult_y: got %h want fffffffffffffffe", y); end
    n_checks++; if (hilo_prf_ptr_val_out !== 1'b1 || gpr_prf_ptr_val_out !== 1'b0)
      begin n_fail++; $display("FAIL mult_vals: got hilo=%b gpr=%b want 1 0", hilo_prf_ptr_val_out, gpr_prf_ptr_val_out); end
    n_checks++; if (rob_ptr_out !== 6'd3 || hilo_prf_ptr_out !== 2'd1)
      begin n_fail++; $display("FAIL mult_tags: got rob=%0d hp=%0d want 3 1", rob_ptr_out, hilo_prf_ptr_out); end
    step();
    n_checks++; if (complete !== 1'b0) begin n_fail++; $display("FAIL mult_consumed: got %b want 0", complete); end
    // Same operands unsigned: 0xFFFFFFFF * 2 = 0x1FFFFFFFE.
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 64'h0, 6'd4, 6'd5, 2'd2);
    step(); idle();
    step(); step(); step();
    n_checks++; if (complete !== 1'b1 || y !== 64'h0000_0001_FFFF_FFFE)
      begin n_fail++; $display("FAIL multu_y: got c=%b y=%h want 1 00000001fffffffe", complete, y); end
    step();
  endtask

  task automatic test_madd();
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h2, 6'd7, 6'd0, 2'd0);
    step();
    set_op(1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1, 64'h2, 6'd8, 6'd0, 2'd1);
    step();
    // Both accumulate flags: madd wins, 2*3 + 10 = 16.
    set_op(1'b1, 1'b0, 1'b1, 1'b1, 32'd2, 32'd3, 64'd10, 6'd9, 6'd0, 2'd2);
    step(); idle();
    step();
    n_checks++; if (complete !== 1'b1 || y !== 64'hFFFF_FFFE_0000_0003)
      begin n_fail++; $display("FAIL maddu_y: got c=%b y=%h want 1 fffffffe00000003", complete, y); end
    step();
    n_checks++; if (complete !== 1'b1 || y !== 64'hFFFF_FFFF_FFFF_FFFF)
      begin n_fail++; $display("FAIL msub_y: got c=%b y=%h want 1 ffffffffffffffff", complete, y); end
    step();
    n_checks++; if (complete !== 1'b1 || y !== 64'd16)
      begin n_fail++; $display("FAIL madd_priority_y: got c=%b y=%h want 1 10", complete, y); end
    step();
  endtask

  task automatic test_back_to_back();
    int nxt = 0;
    int got = 0;
    for (int c = 0; c < 30; c++) begin
      wb_stall = (c >= 4 && c <= 7);
      if (nxt < 6) set_op(1'b0, 1'b1, 1'b0, 1'b0, W'(nxt + 1), W'(nxt + 2), 64'h0,
                          ROB_W'(nxt), PRF_W'(nxt), 2'd0);
      else idle();
      #1;
      if (c < 4) begin
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_fill c=%0d: got %b want 1", c, ready); end
      end
      if (c == 4) begin
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b want 0", ready); end
      end
      if (c >= 4 && c <= 7) begin
        n_checks++; if (complete !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_hold c=%0d: got %b want 1", c, complete); end
      end
      if (complete === 1'b1) begin
        if (got >= 6) begin
          n_checks++; n_fail++;
          $display("FAIL b2b_extra c=%0d: got extra result rob=%0d want none", c, rob_ptr_out);
        end else begin
          n_checks++; if (rob_ptr_out !== ROB_W'(got))
            begin n_fail++; $display("FAIL b2b_order c=%0d: got rob=%0d want %0d", c, rob_ptr_out, got); end
          n_checks++; if (y !== 64'((got + 1) * (got + 2)) || gpr_prf_ptr_val_out !== 1'b1)
            begin n_fail++; $display("FAIL b2b_y c=%0d: got y=%0d gv=%b want %0d 1", c, y, gpr_prf_ptr_val_out, (got + 1) * (got + 2)); end
        end
        if (!wb_stall) got++;
      end
      if (go && ready) nxt++;
      @(posedge clk); #1;
    end
    wb_stall = 1'b0; idle();
    n_checks++; if (got != 6) begin n_fail++; $display("FAIL b2b_count: got %0d results want 6", got); end
    n_checks++; if (nxt != 6) begin n_fail++; $display("FAIL b2b_issued: got %0d issues want 6", nxt); end
  endtask

  task automatic test_flush();
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd2, 64'h0, 6'd1, 6'd1, 2'd0);
    step(); idle();
    step();
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 32'd3, 64'h0, 6'd2, 6'd2, 2'd0);
    step();
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'd4, 32'd4, 64'h0, 6'd3, 6'd3, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; idle();
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", ready); end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (complete !== 1'b0) begin n_fail++; $display("FAIL flush_complete k=%0d: got %b want 0", k, complete); end
      step();
    end
  endtask

  task automatic test_reset_mid_stall();
    wb_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_op(1'b0, 1'b1, 1'b0, 1'b0, W'(k + 7), 32'd3, 64'h0, ROB_W'(k + 10), PRF_W'(k), 2'd0);
      step();
    end
    idle();
    #1;
    n_checks++; if (ready !== 1'b0 || complete !== 1'b1 || rob_ptr_out !== 6'd10)
      begin n_fail++; $display("FAIL stall_full: got r=%b c=%b rob=%0d want 0 1 10", ready, complete, rob_ptr_out); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (complete !== 1'b0 || y !== 64'h0 || ready !== 1'b1)
      begin n_fail++; $display("FAIL midreset: got c=%b y=%h r=%b want 0 0 1", complete, y, ready); end
    wb_stall = 1'b0;
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5, 64'h0, 6'd20, 6'd9, 2'd0);
    step(); idle();
    step(); step(); step();
    n_checks++; if (complete !== 1'b1 || y !== 64'd15 || gpr_prf_ptr_val_out !== 1'b1 || rob_ptr_out !== 6'd20)
      begin n_fail++; $display("FAIL post_reset_mul: got c=%b y=%0d gv=%b rob=%0d want 1 15 1 20", complete, y, gpr_prf_ptr_val_out, rob_ptr_out); end
    step();
  endtask

`ifdef MUL_PIPE_PERF_EN
  task automatic test_perf();
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (perf_ops !== 32'd0 || perf_stall !== 32'd0)
      begin n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", perf_ops, perf_stall); end
    for (int k = 0; k < 3; k++) begin
      set_op(1'b0, 1'b1, 1'b0, 1'b0, W'(k), 32'd1, 64'h0, ROB_W'(k), PRF_W'(k), 2'd0);
      step();
    end
    idle();
    step();
    wb_stall = 1'b1;
    step(); step();
    wb_stall = 1'b0;
    for (int k = 0; k < 6; k++) step();
    n_checks++; if (perf_ops !== 32'd3) begin n_fail++; $display("FAIL perf_ops: got %0d want 3", perf_ops); end
    n_checks++; if (perf_stall !== 32'd2) begin n_fail++; $display("FAIL perf_stall: got %0d want 2", perf_stall); end
    reset = 1'b1; step(); reset = 1'b0;
    n_checks++; if (perf_ops !== 32'd0 || perf_stall !== 32'd0)
      begin n_fail++; $display("FAIL perf_rereset: got %0d/%0d want 0/0", perf_ops, perf_stall); end
  endtask
`endif

  initial begin
    reset = 1'b1; flush = 1'b0; go = 1'b0; wb_stall = 1'b0;
    unsigned_mul = 1'b0; is_mul = 1'b0; is_madd = 1'b0; is_msub = 1'b0;
    src_A = '0; src_B = '0; src_hilo = '0;
    rob_ptr_in = '0; gpr_prf_ptr_in = '0; hilo_prf_ptr_in = '0;
    test_reset();
    test_mult();
    test_madd();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
`ifdef MUL_PIPE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
